// File: rtl/conv_layer_input_controller.sv
// conv_layer_input_controller
//
// Frame sequencer for the input interface of a convolution layer. One start
// request runs a full frame: a single PRELOAD, then for every output row a
// SHIFT (with an accumulator clear before it and a capture after it),
// separated by LOADs. There is no LOAD after the last row. Each command is
// held for one enabled cycle, and the controller then waits for the
// matching *_FIN acknowledge.
//
// Optional feature (compile-time macro CONV_CTRL_TIMEOUT_EN):
//   An 8-bit watchdog counts enabled cycles spent in any WAIT state. When it
//   reaches TIMEOUT_CYCLES, the frame is abandoned: sticky err is set, the
//   FSM returns to IDLE, and no done pulse is produced. Without the macro,
//   err stays 0 and the WAIT states wait forever.
//
// Parameters
//   ARRAY_SIZE      rows per frame (1..8)
//   TIMEOUT_CYCLES  watchdog limit in enabled WAIT cycles (1..256)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle frame request; only honoured in IDLE with halt=0
//   halt         level pause; freezes all state and registered outputs
//   ack[1:0]     interface acknowledge: 0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN
//   cmd[1:0]     interface command:     0 IDLE, 1 PRELOAD,     2 SHIFT,     3 LOAD
//   if_enable    interface enable, ~halt
//   busy         high whenever the FSM is not in IDLE
//   row_idx[2:0] current output row
//   acc_clear    pulse alongside each SHIFT command
//   acc_capture  pulse in the cycle after SHIFT_FIN
//   done         pulse at the end of a completed frame
//   err          sticky watchdog timeout flag
module conv_layer_input_controller #(
  parameter int ARRAY_SIZE     = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt,
  input  logic [1:0] ack,
  output logic [1:0] cmd,
  output logic       if_enable,
  output logic       busy,
  output logic [2:0] row_idx,
  output logic       acc_clear,
  output logic       acc_capture,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] CMD_IDLE        = 2'd0;
  localparam logic [1:0] CMD_PRELOAD     = 2'd1;
  localparam logic [1:0] CMD_SHIFT       = 2'd2;
  localparam logic [1:0] CMD_LOAD        = 2'd3;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;
  localparam logic [2:0] LAST_ROW        = 3'(ARRAY_SIZE - 1);

  // row_idx is 3 bits wide and the watchdog is 8 bits wide.
  if (ARRAY_SIZE < 1 || ARRAY_SIZE > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
    $error("conv_layer_input_controller: ARRAY_SIZE must be 1..8 and TIMEOUT_CYCLES 1..256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_REQ,
    S_PRE_WAIT,
    S_SH_REQ,
    S_SH_WAIT,
    S_LD_REQ,
    S_LD_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] row_nxt;
  logic [1:0] cmd_nxt;
  logic       err_nxt;
  logic       ack_hit;
  logic       timeout;

  assign if_enable = ~halt;
  assign busy      = (state != S_IDLE);

  // Only the acknowledge that the current WAIT state expects counts.
  // Every other value, and any value seen outside a WAIT state, is ignored.
  always_comb begin
    ack_hit = 1'b0;
    case (state)
      S_PRE_WAIT: ack_hit = (ack == ACK_PRELOAD_FIN);
      S_SH_WAIT:  ack_hit = (ack == ACK_SHIFT_FIN);
      S_LD_WAIT:  ack_hit = (ack == ACK_LOAD_FIN);
      default:    ack_hit = 1'b0;
    endcase
  end

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt;
  logic [7:0] wd_nxt;
  logic       in_wait;

  assign in_wait = (state == S_PRE_WAIT) || (state == S_SH_WAIT) || (state == S_LD_WAIT);

  // The TIMEOUT_CYCLES-th consecutive unanswered WAIT cycle fires the
  // timeout. The counter restarts from zero whenever a WAIT state is left.
  always_comb begin
    timeout = in_wait && !ack_hit && (wd_cnt == WD_LAST);
    wd_nxt  = 8'd0;
    if (in_wait && !ack_hit && !timeout) begin
      wd_nxt = wd_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= 8'd0;
    end else if (!halt) begin
      wd_cnt <= wd_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    err_nxt   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_PRE_REQ;
          row_nxt   = 3'd0;
          err_nxt   = 1'b0;
        end
      end
      S_PRE_REQ:  state_nxt = S_PRE_WAIT;
      S_PRE_WAIT: if (ack_hit) state_nxt = S_SH_REQ;
      S_SH_REQ:   state_nxt = S_SH_WAIT;
      S_SH_WAIT: begin
        if (ack_hit) begin
          state_nxt = (row_idx == LAST_ROW) ? S_DONE : S_LD_REQ;
        end
      end
      S_LD_REQ: begin
        state_nxt = S_LD_WAIT;
        row_nxt   = row_idx + 3'd1;
      end
      S_LD_WAIT:  if (ack_hit) state_nxt = S_SH_REQ;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase

    if (timeout) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
    end

    cmd_nxt = CMD_IDLE;
    case (state_nxt)
      S_PRE_REQ: cmd_nxt = CMD_PRELOAD;
      S_SH_REQ:  cmd_nxt = CMD_SHIFT;
      S_LD_REQ:  cmd_nxt = CMD_LOAD;
      default:   cmd_nxt = CMD_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state they belong to. Holding everything while halt is high
  // makes an interrupted REQ state re-drive its command once after release.
  // LD_REQ and DONE are entered only from SH_WAIT on SHIFT_FIN, so entering
  // either one marks the row capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row_idx     <= 3'd0;
      err         <= 1'b0;
      cmd         <= CMD_IDLE;
      acc_clear   <= 1'b0;
      acc_capture <= 1'b0;
      done        <= 1'b0;
    end else if (!halt) begin
      state       <= state_nxt;
      row_idx     <= row_nxt;
      err         <= err_nxt;
      cmd         <= cmd_nxt;
      acc_clear   <= (state_nxt == S_SH_REQ);
      acc_capture <= (state_nxt == S_LD_REQ) || (state_nxt == S_DONE);
      done        <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_conv_layer_input_controller.sv
// Self-checking bench for conv_layer_input_controller.
// Random start/halt/junk-ack stimulus with a responding interface model.
// Commands and captures are logged as transactions whenever they are
// presented on an enabled edge, and then compared with the frame the
// controller is required to produce. Latency and hold rules are checked
// cycle by cycle. CONV_CTRL_TIMEOUT_EN enables the watchdog scenario.
`timescale 1ns/1ps
module tb_conv_layer_input_controller;

  localparam int N = 6;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       halt  = 1'b0;
  logic [1:0] ack   = 2'd0;
  logic [1:0] cmd;
  logic       if_enable;
  logic       busy;
  logic [2:0] row_idx;
  logic       acc_clear;
  logic       acc_capture;
  logic       done;
  logic       err;

  conv_layer_input_controller #(
    .ARRAY_SIZE    (N),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .ack        (ack),
    .cmd        (cmd),
    .if_enable  (if_enable),
    .busy       (busy),
    .row_idx    (row_idx),
    .acc_clear  (acc_clear),
    .acc_capture(acc_capture),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int cmd_log[$];
  int cap_log[$];
  int done_cnt;
  bit active;
  int awaited;      // ack value the interface owes, 0 when none
  int ack_cnt;      // enabled cycles before the interface answers
  int halt_left;
  bit frame_end;
  bit did_ld_halt, did_spur, did_rst;

  // Outputs presented before the most recent edge
  int p_cmd, p_row;
  bit p_clear, p_cap, p_done, p_busy;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic snapshot();
    p_cmd   = int'(cmd);
    p_row   = int'(row_idx);
    p_clear = acc_clear;
    p_cap   = acc_capture;
    p_done  = done;
    p_busy  = busy;
  endtask

  task automatic apply_reset();
    start = 1'b0;
    halt  = 1'b0;
    ack   = 2'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd",   int'(cmd),         0);
    chk("rst_busy",  int'(busy),        0);
    chk("rst_row",   int'(row_idx),     0);
    chk("rst_clear", int'(acc_clear),   0);
    chk("rst_cap",   int'(acc_capture), 0);
    chk("rst_done",  int'(done),        0);
    chk("rst_err",   int'(err),         0);
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b1;
    active    = 1'b0;
    awaited   = 0;
    ack_cnt   = 0;
    halt_left = 0;
    done_cnt  = 0;
    cmd_log.delete();
    cap_log.delete();
    snapshot();
  endtask

  // Evaluate the edge that just passed, using the inputs applied to it
  task automatic step(input int mode);
    bit accepted;
    bit got_ack;
    chk("if_enable", int'(if_enable), int'(!halt));
    chk("err_zero", int'(err), 0);
    if (halt) begin
      chk("hold_cmd",   int'(cmd),         p_cmd);
      chk("hold_row",   int'(row_idx),     p_row);
      chk("hold_busy",  int'(busy),        int'(p_busy));
      chk("hold_clear", int'(acc_clear),   int'(p_clear));
      chk("hold_cap",   int'(acc_capture), int'(p_cap));
      chk("hold_done",  int'(done),        int'(p_done));
    end else begin
      accepted = start && !active;
      got_ack  = (awaited != 0) && (int'(ack) == awaited);
      if (accepted) begin
        chk("start_to_preload", int'(cmd), 1);
        chk("busy_rise", int'(busy), 1);
        active = 1'b1;
      end
      if (got_ack) begin
        if (awaited == 2) begin
          chk("capture_pulse", int'(acc_capture), 1);
          if (p_row == N - 1) begin
            chk("last_row_done", int'(done), 1);
            chk("no_load_after_last", int'(cmd), 0);
          end else begin
            chk("shift_to_load", int'(cmd), 3);
          end
        end else begin
          chk("ack_to_shift", int'(cmd), 2);
          chk("clear_pulse", int'(acc_clear), 1);
        end
        awaited = 0;
      end
      if (p_cmd != 0) begin
        cmd_log.push_back(p_cmd);
        awaited = p_cmd;
        ack_cnt = (mode == 0) ? 2 : int'($urandom_range(0, 4));
      end
      if (!got_ack && awaited != 0) chk("wait_idle_cmd", int'(cmd), 0);
      if (p_cap) cap_log.push_back(p_row);
      if (p_done) begin
        done_cnt++;
        active    = 1'b0;
        frame_end = 1'b1;
        chk("busy_fall", int'(busy), 0);
        chk("done_single", int'(done), 0);
      end
    end
    chk("clear_iff_shift", int'(acc_clear), int'(cmd == 2'd2));
    snapshot();
  endtask

  task automatic drive(input int mode);
    bit h;
    bit s;
    int a;
    if (halt_left > 0) begin
      h = 1'b1;
      halt_left--;
    end else if (mode == 1 && !did_ld_halt && cmd == 2'd3) begin
      h = 1'b1;
      halt_left = 9;
      did_ld_halt = 1'b1;
    end else if (mode >= 1 && $urandom_range(0, 11) == 0) begin
      h = 1'b1;
      halt_left = int'($urandom_range(0, 9));
    end else begin
      h = 1'b0;
    end

    if (!active) s = ($urandom_range(0, 3) == 0);
    else if (mode == 1 && !did_spur && awaited == 2 && p_row == 2) begin
      s = 1'b1;
      did_spur = 1'b1;
    end else s = (mode >= 1) && ($urandom_range(0, 19) == 0);

    a = 0;
    if (!h && awaited != 0) begin
      if (ack_cnt == 0) a = awaited;
      else ack_cnt--;
    end
    if (a == 0 && mode >= 1) begin
      if (awaited == 1) a = 3;
      else if ($urandom_range(0, 2) == 0) a = int'($urandom_range(0, 3));
      if (a == awaited) a = 0;
    end

    halt  = h;
    start = s;
    ack   = 2'(a);
  endtask

  task automatic check_frame();
    int exp_cmds[$];
    exp_cmds.push_back(1);
    for (int r = 0; r < N; r++) begin
      exp_cmds.push_back(2);
      if (r < N - 1) exp_cmds.push_back(3);
    end
    chk("frame_cmd_count", cmd_log.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size() && i < cmd_log.size(); i++)
      chk("frame_cmd_seq", cmd_log[i], exp_cmds[i]);
    chk("frame_cap_count", cap_log.size(), N);
    for (int i = 0; i < cap_log.size() && i < N; i++)
      chk("frame_cap_row", cap_log[i], i);
    chk("frame_done_count", done_cnt, 1);
  endtask

  task automatic run_frame(input int mode);
    int cyc;
    cmd_log.delete();
    cap_log.delete();
    done_cnt    = 0;
    frame_end   = 1'b0;
    did_ld_halt = 1'b0;
    did_spur    = 1'b0;
    did_rst     = 1'b0;
    cyc         = 0;
    while (!frame_end && cyc < 3000) begin
      tick();
      cyc++;
      step(mode);
      if (mode == 2 && !did_rst && awaited == 2 && row_idx == 3'd4) begin
        apply_reset();
        did_rst = 1'b1;
      end
      if (!frame_end) drive(mode);
    end
    if (!frame_end) chk("frame_budget", 0, 1);
    start = 1'b0;
    halt  = 1'b0;
    ack   = 2'd0;
    check_frame();
  endtask

`ifdef CONV_CTRL_TIMEOUT_EN
  task automatic timeout_test();
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_preload", int'(cmd), 1);
    tick();
    cyc = 0;
    while (busy && cyc < 400) begin
      tick();
      cyc++;
      chk("to_no_done", int'(done), 0);
    end
    chk("to_cycles", cyc, 255);
    chk("to_err", int'(err), 1);
    chk("to_busy", int'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_err_cleared", int'(err), 0);
    apply_reset();
  endtask
`endif

  initial begin
    #1;
    apply_reset();
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(1);
    run_frame(3);
`ifdef CONV_CTRL_TIMEOUT_EN
    timeout_test();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "time budget exhausted");
  end

endmodule

// File: doc/conv_layer_input_controller.md
CONV_LAYER_INPUT_CONTROLLER -- requirements
Module: conv_layer_input_controller

Interface
REQ-001 Parameter ARRAY_SIZE, default 6: number of output rows per frame (one SHIFT pass each).
REQ-002 Parameter TIMEOUT_CYCLES, default 255: ack watchdog limit, used only with CONV_CTRL_TIMEOUT_EN.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to process one frame.
REQ-006 halt  input  1  level pause: freezes this controller and the input interface.
REQ-007 ack  input  2  from input interface: 0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN.
REQ-008 cmd  output  2  to input interface: 0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD.
REQ-009 if_enable  output  1  enable to input interface, equal to ~halt (combinational).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 row_idx  output  3  current output row, 0..ARRAY_SIZE-1.
REQ-012 acc_clear  output  1  one-cycle pulse: clear kernel accumulators before each row's SHIFT.
REQ-013 acc_capture  output  1  one-cycle pulse: row result valid (SHIFT_FIN received).
REQ-014 done  output  1  one-cycle pulse at end of frame.
REQ-015 err  output  1  sticky ack-timeout flag.

Function
REQ-016 FSM states: IDLE, PRE_REQ, PRE_WAIT, SH_REQ, SH_WAIT, LD_REQ, LD_WAIT, DONE; cmd, acc_clear, acc_capture and done are registered Moore outputs.
REQ-017 IDLE: cmd=0; start=1 and halt=0 -> PRE_REQ, row_idx<=0, err<=0; start while busy or while halt=1 is ignored.
REQ-018 PRE_REQ: cmd=1 for exactly one cycle -> PRE_WAIT.
REQ-019 PRE_WAIT: cmd=0; ack==1 -> SH_REQ.
REQ-020 SH_REQ: cmd=2 and acc_clear=1 for exactly one cycle -> SH_WAIT.
REQ-021 SH_WAIT: cmd=0; ack==2 -> acc_capture=1 next cycle; if row_idx==ARRAY_SIZE-1 -> DONE, else LD_REQ.
REQ-022 LD_REQ: cmd=3 for one cycle, row_idx<=row_idx+1 -> LD_WAIT.
REQ-023 LD_WAIT: cmd=0; ack==3 -> SH_REQ.
REQ-024 DONE: done=1 for one cycle -> IDLE; no LOAD is issued after the last row.
REQ-025 Ack values other than the one awaited are ignored in every WAIT state; any ack in IDLE, REQ or DONE states is ignored.
REQ-026 halt=1: FSM, row_idx, watchdog counter and all registered outputs hold; a REQ state interrupted by halt re-drives its cmd for one enabled cycle after halt falls.
REQ-027 Per frame: exactly 1 PRELOAD, ARRAY_SIZE SHIFT, ARRAY_SIZE-1 LOAD commands, ARRAY_SIZE acc_capture pulses, 1 done pulse.
REQ-028 Minimum latency: start -> cmd=1 one cycle later; ack==1 -> cmd=2 one cycle later.

Reset
REQ-029 rst_n low, at any time including mid-frame: state IDLE, cmd=0, row_idx=0, busy=0, acc_clear=0, acc_capture=0, done=0, err=0, watchdog=0; no done pulse is generated for an aborted frame.
REQ-030 First start accepted is the first one seen on a rising edge with rst_n high.

Configuration
REQ-031 Macro CONV_CTRL_TIMEOUT_EN defined: 8-bit watchdog counts enabled cycles in any WAIT state, clears on state exit; reaching TIMEOUT_CYCLES -> err<=1, FSM -> IDLE, cmd=0, no done pulse.
REQ-032 Macro CONV_CTRL_TIMEOUT_EN undefined: no watchdog, err constant 0, WAIT states wait indefinitely.

Verification
REQ-033 Reset, start with interface model acking after 3 cycles -> cmd sequence 1,2,3,2,3,2,3,2,3,2,3,2; row_idx 0..5; 6 acc_capture pulses; 1 done pulse; busy falls with done.
REQ-034 start pulsed in SH_WAIT of row 2 -> ignored; frame completes with exactly 6 SHIFT commands and 1 done.
REQ-035 halt=1 for 10 cycles during LD_REQ -> cmd held, if_enable=0; after halt falls cmd=3 driven once; frame completes normally.
REQ-036 ack==3 injected in PRE_WAIT -> no transition; subsequent ack==1 -> cmd=2 next cycle.
REQ-037 With CONV_CTRL_TIMEOUT_EN, no ack after PRELOAD -> err=1 after 255 cycles, busy=0, no done; next start clears err.
REQ-038 rst_n asserted in SH_WAIT of row 4 -> all outputs zero immediately; fresh start runs a full 6-row frame.
